// File: rtl/pad_test_pkg.sv
// Shared types and PRBS10 helpers for the pad ring loopback BIST blocks.
// x^10 + x^7 + 1 Fibonacci LFSR: feedback from bits 9 and 6, shifted in at bit 0.
package pad_test_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } pad_test_state_e;

   localparam int PRBS_W = 10;

   // Feedback taps: bit 9 and bit 6.
   localparam logic [PRBS_W-1:0] PRBS10_TAPS = 10'h240;

   localparam int SYNC_STAGES = 2;

   // An all-zero LFSR state would lock up, so a zero seed is replaced by this value.
   localparam logic [PRBS_W-1:0] SEED_ZERO_SUB = 10'h001;

   function automatic logic [PRBS_W-1:0] prbs10_step(input logic [PRBS_W-1:0] s);
      return {s[PRBS_W-2:0], ^(s & PRBS10_TAPS)};
   endfunction

   function automatic logic [PRBS_W-1:0] prbs10_seed_fix(input logic [PRBS_W-1:0] s);
      return (s == '0) ? SEED_ZERO_SUB : s;
   endfunction

endpackage

// File: rtl/prbs10_gen.sv
// PRBS10 pattern generator with a seed load and an advance enable.
// A zero seed is substituted so the register never enters the lock-up state.
module prbs10_gen
   import pad_test_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              en,
   input  logic [PRBS_W-1:0] seed,
   output logic [PRBS_W-1:0] state
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SEED_ZERO_SUB;
      end else if (load) begin
         state <= prbs10_seed_fix(seed);
      end else if (en) begin
         state <= prbs10_step(state);
      end
   end

endmodule

// File: rtl/pad_loopback_tester.sv
// Core-side pad loopback tester: drives PRBS10 onto c2p, checks the returning
// p2c word against a delayed copy, and records mismatch count and failing lanes.
module pad_loopback_tester
   import pad_test_pkg::*;
#(
   parameter int WIDTH   = 10,
   parameter int MAX_LAT = 7,
   parameter int ERR_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] seed,
   input  logic [2:0]       lat_sel,
   input  logic [ERR_W-1:0] test_len,
   output logic [WIDTH-1:0] c2p,
   input  logic [WIDTH-1:0] p2c,
   output logic             busy,
   output logic             done,
   output logic [ERR_W-1:0] err_cnt,
   output logic [WIDTH-1:0] err_lanes
);

   localparam int DL_D   = MAX_LAT + SYNC_STAGES;
   localparam int TAP_W  = $clog2(DL_D);
   localparam int PCNT_W = TAP_W + 1;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   pad_test_state_e   state_q, state_nxt;
   logic              launch, cmp_en, lfsr_en, busy_nxt;
   logic [PRBS_W-1:0] lfsr, lfsr_nxt;

   logic [2:0]        lat_cl;
   logic [TAP_W-1:0]  tap_ld, tap_q;
   logic [PCNT_W-1:0] prime_ld, prime_cnt_q;
   logic [ERR_W-1:0]  words_ld, words_cnt_q;

   logic [WIDTH-1:0]  p2c_p1, p2c_p2;
   logic [WIDTH-1:0]  dly_q [DL_D];
   logic [WIDTH-1:0]  expected, mism;

   // Run parameters captured at launch; total loopback latency is lat + sync stages.
   always_comb begin
      lat_cl   = (int'(lat_sel) > MAX_LAT) ? 3'(MAX_LAT) : lat_sel;
      tap_ld   = TAP_W'(lat_cl) + TAP_W'(SYNC_STAGES - 1);
      prime_ld = PCNT_W'(lat_cl) + PCNT_W'(SYNC_STAGES);
      words_ld = (test_len == '0) ? ERR_W'(1) : test_len;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // stop overrides everything, including a start in the same cycle and the compare.
   always_comb begin
      state_nxt = state_q;
      launch    = 1'b0;
      cmp_en    = 1'b0;
      if (stop) begin
         state_nxt = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_nxt = PRIME;
                  launch    = 1'b1;
               end
            end
            PRIME: begin
               if (prime_cnt_q == PCNT_W'(1)) state_nxt = CHECK;
            end
            CHECK: begin
               cmp_en = 1'b1;
               if (words_cnt_q == ERR_W'(1)) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign lfsr_en  = (state_q == PRIME) || (state_q == CHECK);
   assign busy_nxt = (state_nxt == PRIME) || (state_nxt == CHECK);

   prbs10_gen u_prbs (
      .clk   (clk),
      .rst   (rst),
      .load  (launch),
      .en    (lfsr_en),
      .seed  (PRBS_W'(seed)),
      .state (lfsr)
   );

   // Look-ahead of the generator so c2p can be a plain register in step with it.
   always_comb begin
      if (launch) begin
         lfsr_nxt = prbs10_seed_fix(PRBS_W'(seed));
      end else if (lfsr_en) begin
         lfsr_nxt = prbs10_step(lfsr);
      end else begin
         lfsr_nxt = lfsr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tap_q       <= '0;
         prime_cnt_q <= '0;
         words_cnt_q <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         busy <= busy_nxt;
         done <= (state_nxt == DONE);
         if (launch) begin
            tap_q       <= tap_ld;
            prime_cnt_q <= prime_ld;
            words_cnt_q <= words_ld;
         end else begin
            if (state_q == PRIME) prime_cnt_q <= prime_cnt_q - 1'b1;
            if (cmp_en)           words_cnt_q <= words_cnt_q - 1'b1;
         end
      end
   end

   // Stage p1/p2: p2c synchroniser; c2p register and expected-word delay line
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p2c_p1 <= '0;
         p2c_p2 <= '0;
         c2p    <= '0;
         for (int i = 0; i < DL_D; i++) dly_q[i] <= '0;
      end else begin
         p2c_p1   <= p2c;
         p2c_p2   <= p2c_p1;
         c2p      <= busy_nxt ? WIDTH'(lfsr_nxt) : '0;
         dly_q[0] <= c2p;
         for (int i = 1; i < DL_D; i++) dly_q[i] <= dly_q[i-1];
      end
   end

   assign expected = dly_q[tap_q];
   assign mism     = p2c_p2 ^ expected;

   // Compare stage: results are registered, so p2c never reaches an output combinationally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt   <= '0;
         err_lanes <= '0;
      end else if (launch) begin
         err_cnt   <= '0;
         err_lanes <= '0;
      end else if (cmp_en) begin
         if (mism != '0) err_cnt <= sat_inc(err_cnt);
         err_lanes <= err_lanes | mism;
      end
   end

endmodule

// File: tb/tb_pad_loopback_tester.sv
// Directed bench for pad_loopback_tester with a bench-side board loopback
// (programmable delay, stuck-at-0 lanes) and a narrow-counter inverted-loopback copy.
module tb_pad_loopback_tester;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, stop;
   logic [9:0]  seed;
   logic [2:0]  lat_sel;
   logic [15:0] test_len;
   logic [9:0]  c2p, p2c;
   logic        busy, done;
   logic [15:0] err_cnt;
   logic [9:0]  err_lanes;

   logic        start_s, stop_s;
   logic [3:0]  test_len_s;
   logic [9:0]  c2p_s, p2c_s;
   logic        busy_s, done_s;
   logic [3:0]  err_cnt_s;
   logic [9:0]  err_lanes_s;

   int          ext_dly;
   logic [9:0]  stuck_mask;
   logic [9:0]  ext_pipe [8];
   logic [9:0]  lb;

   int          checks = 0;
   int          passes = 0;
   int          fails  = 0;

   always #5 clk = ~clk;

   pad_loopback_tester #(.WIDTH(10), .MAX_LAT(7), .ERR_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .seed(seed),
      .lat_sel(lat_sel), .test_len(test_len), .c2p(c2p), .p2c(p2c),
      .busy(busy), .done(done), .err_cnt(err_cnt), .err_lanes(err_lanes)
   );

   pad_loopback_tester #(.WIDTH(10), .MAX_LAT(7), .ERR_W(4)) dut_sat (
      .clk(clk), .rst(rst), .start(start_s), .stop(stop_s), .seed(seed),
      .lat_sel(lat_sel), .test_len(test_len_s), .c2p(c2p_s), .p2c(p2c_s),
      .busy(busy_s), .done(done_s), .err_cnt(err_cnt_s), .err_lanes(err_lanes_s)
   );

   always @(posedge clk) begin
      ext_pipe[0] <= c2p;
      for (int i = 1; i < 8; i++) ext_pipe[i] <= ext_pipe[i-1];
   end

   always_comb begin
      lb = c2p;
      if (ext_dly > 0) lb = ext_pipe[ext_dly-1];
      p2c = lb & ~stuck_mask;
   end

   assign p2c_s = ~c2p_s;

   function automatic logic [9:0] step(input logic [9:0] s);
      return {s[8:0], s[9] ^ s[6]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [9:0] sd, input logic [2:0] ls, input logic [15:0] tl);
      seed     = sd;
      lat_sel  = ls;
      test_len = tl;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic wait_done(input int n0, input int bound, output int n);
      n = n0;
      while (done !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0]  exp1 [8];
      logic [9:0]  s, prev;
      logic [15:0] m_cnt;
      logic [9:0]  m_lanes;
      int          n;

      exp1 = '{10'h001, 10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040, 10'h081};

      rst = 1'b1; start = 1'b0; stop = 1'b0; seed = '0; lat_sel = '0; test_len = '0;
      start_s = 1'b0; stop_s = 1'b0; test_len_s = '0;
      ext_dly = 0; stuck_mask = '0;
      tick(); tick();
      check("reset_c2p", c2p, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_err_cnt", err_cnt, 0);
      check("reset_err_lanes", err_lanes, 0);
      rst = 1'b0;
      tick();

      // Ideal loopback, seed 1, 20 words
      launch(10'h001, 3'd0, 16'd20);
      check("ideal_busy", busy, 1);
      check("ideal_c2p_0", c2p, exp1[0]);
      for (int i = 1; i < 8; i++) begin
         tick();
         check($sformatf("ideal_c2p_%0d", i), c2p, exp1[i]);
      end
      wait_done(7, 60, n);
      check("ideal_done_latency", n, 22);
      check("ideal_err_cnt", err_cnt, 0);
      check("ideal_err_lanes", err_lanes, 0);
      check("ideal_done_busy", busy, 0);
      check("ideal_done_c2p", c2p, 0);

      // Lane 3 stuck at 0
      stuck_mask = 10'h008;
      tick(); tick();
      s = 10'h2A5; m_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (s[3]) m_cnt++;
         s = step(s);
      end
      launch(10'h2A5, 3'd0, 16'd100);
      wait_done(0, 200, n);
      check("stuck_done_latency", n, 102);
      check("stuck_err_cnt", err_cnt, m_cnt);
      check("stuck_err_lanes", err_lanes, 10'h008);

      // External delay 3: matched and short latency selection
      stuck_mask = '0; ext_dly = 3;
      repeat (5) tick();
      launch(10'h155, 3'd3, 16'd40);
      wait_done(0, 100, n);
      check("lat3_done_latency", n, 45);
      check("lat3_err_cnt", err_cnt, 0);
      check("lat3_err_lanes", err_lanes, 0);
      repeat (5) tick();
      s = 10'h155; prev = '0; m_cnt = 0; m_lanes = '0;
      for (int i = 0; i < 40; i++) begin
         if (prev != s) m_cnt++;
         m_lanes |= prev ^ s;
         prev = s;
         s = step(s);
      end
      launch(10'h155, 3'd2, 16'd40);
      wait_done(0, 100, n);
      check("lat2_done_latency", n, 44);
      check("lat2_err_nonzero", err_cnt != 0, 1);
      check("lat2_err_cnt", err_cnt, m_cnt);
      check("lat2_err_lanes", err_lanes, m_lanes);

      // Zero seed, zero length
      ext_dly = 0;
      repeat (3) tick();
      launch(10'h000, 3'd0, 16'd0);
      check("zero_seed_c2p", c2p, 10'h001);
      check("zero_start_clears_err", err_cnt, 0);
      wait_done(0, 20, n);
      check("zero_len_done_latency", n, 3);
      check("zero_len_err_cnt", err_cnt, 0);

      // stop mid-CHECK: 28 words compared before the stop edge
      stuck_mask = 10'h008;
      tick(); tick();
      s = 10'h2A5; m_cnt = 0; m_lanes = '0;
      for (int i = 0; i < 28; i++) begin
         if (s[3]) m_cnt++;
         m_lanes |= s & 10'h008;
         s = step(s);
      end
      launch(10'h2A5, 3'd0, 16'd100);
      repeat (30) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("stop_busy", busy, 0);
      check("stop_done", done, 0);
      check("stop_c2p", c2p, 0);
      check("stop_err_cnt", err_cnt, m_cnt);
      check("stop_err_lanes", err_lanes, m_lanes);
      repeat (3) tick();
      check("stop_err_cnt_hold", err_cnt, m_cnt);
      check("stop_idle_busy", busy, 0);
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      check("start_stop_same_cycle_busy", busy, 0);

      // Asynchronous reset during PRIME
      stuck_mask = '0;
      launch(10'h3FF, 3'd7, 16'd10);
      repeat (3) tick();
      check("prime_busy", busy, 1);
      check("prime_c2p_nonzero", c2p != 0, 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_c2p", c2p, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_done", done, 0);
      check("async_rst_err_cnt", err_cnt, 0);
      check("async_rst_err_lanes", err_lanes, 0);
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_busy", busy, 0);

      // Inverted loopback on the 4-bit counter build; test_len is capped at 15 by its width
      seed = 10'h0F0; lat_sel = 3'd0; test_len_s = 4'hF;
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      n = 0;
      repeat (5) begin
         tick();
         n++;
      end
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      n++;
      check("sat_busy_after_start", busy_s, 1);
      while (done_s !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      check("sat_done_latency", n, 17);
      check("sat_err_cnt", err_cnt_s, 4'hF);
      check("sat_err_lanes", err_lanes_s, 10'h3FF);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
